handshake_arb: RTL

HANDSHAKE_ARB -- requirements
Module: handshake_arb

---
 rtl/handshake_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/handshake_arb.sv
// Multi-channel one-entry buffers feeding a single destination through a two-state output FSM.
// Define HANDSHAKE_ARB_RR_EN for round-robin arbitration; otherwise the lowest pending index wins.
module handshake_arb #(
  parameter  int WIDTH = 32,
  parameter  int CH    = 4,
  localparam int CHW   = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       sready,
  input  logic [CH*WIDTH-1:0] din,
  output logic [CH-1:0]       sidle,
  input  logic                dbusy,
  output logic                dvalid,
  output logic [WIDTH-1:0]    dout,
  output logic [CHW-1:0]      dch
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CH-1:0]    pend_q, pend_d;
  logic [WIDTH-1:0] data_q [CH];
  logic [WIDTH-1:0] data_d [CH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CHW-1:0]   dch_q, dch_d;

  logic [CHW-1:0]   win_s;
  logic             any_s;
  logic             grant_s;
  logic [CH-1:0]    sidle_s;

  assign any_s   = |pend_q;
  assign grant_s = (state_q == IDLE) && !dbusy && any_s;

`ifdef HANDSHAKE_ARB_RR_EN
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW:0]   idx_s;
  logic           found_s;

  // Round-robin winner: first pending channel at or after ptr, wrapping CH-1 -> 0.
  always_comb begin
    win_s   = {CHW{1'b0}};
    found_s = 1'b0;
    idx_s   = {(CHW+1){1'b0}};
    for (int j = 0; j < CH; j++) begin
      idx_s = {1'b0, ptr_q} + (CHW+1)'(j);
      if (idx_s >= (CHW+1)'(CH)) begin
        idx_s = idx_s - (CHW+1)'(CH);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && pend_q[idx_s[CHW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[CHW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves past the winner only on a grant.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_s) begin
      ptr_d = (win_s == CHW'(CH-1)) ? {CHW{1'b0}} : win_s + CHW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= {CHW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest pending index as winner.
  always_comb begin
    win_s = {CHW{1'b0}};
    for (int j = CH-1; j >= 0; j--) begin
      if (pend_q[j]) begin
        win_s = CHW'(j);
      end else begin
        win_s = win_s;
      end
    end
  end
`endif

  // Next-state for FSM, output word and per-channel buffers.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    data_d  = data_q;
    dout_d  = dout_q;
    dch_d   = dch_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d        = SEND;
          dout_d         = data_q[win_s];
          dch_d          = win_s;
          pend_d[win_s]  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SEND:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A granted channel still has pend_q set here, so it cannot reload on its grant edge.
    for (int i = 0; i < CH; i++) begin
      if (sready[i] && !pend_q[i]) begin
        pend_d[i] = 1'b1;
        data_d[i] = din[i*WIDTH +: WIDTH];
      end else begin
        pend_d[i] = pend_d[i];
      end
    end
  end

  // State, buffer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= {CH{1'b0}};
      dout_q  <= {WIDTH{1'b0}};
      dch_q   <= {CHW{1'b0}};
      for (int i = 0; i < CH; i++) begin
        data_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      dch_q   <= dch_d;
      for (int i = 0; i < CH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // A channel stays busy through the cycle its word is on the bus, so sidle rises one cycle after the grant.
  always_comb begin
    sidle_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      sidle_s[i] = !(pend_q[i] || ((state_q == SEND) && (dch_q == CHW'(i))));
    end
  end

  assign sidle  = sidle_s;
  assign dvalid = (state_q == SEND);
  assign dout   = dout_q;
  assign dch    = dch_q;

endmodule
